// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder mantissa add/normalize stage.
package fp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StNorm,
    StOut
  } state_e;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam int unsigned MANT_W  = 24;

  function automatic logic [31:0] pack_fp(input logic       sign,
                                          input logic [7:0]  exp,
                                          input logic [22:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_norm_shift.sv
// One normalization step: picks shift direction, next exponent and whether the
// result is final (normalized, zero, overflow or underflow).
module fp_norm_shift
  import fp_pkg::*;
#(
  parameter int unsigned MAX_LSHIFT = 24,
  parameter int unsigned CNT_W      = 5
) (
  input  logic [MANT_W:0]   mag_i,
  input  logic [7:0]        exp_i,
  input  logic              sign_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic [MANT_W:0]   mag_o,
  output logic [7:0]        exp_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              done_o,
  output logic [31:0]       result_o,
  output logic              ovf_o,
  output logic              unf_o,
  output logic              zero_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_LSHIFT);

  logic [7:0] exp_inc;
  logic [7:0] exp_dec;

  assign exp_inc = exp_i + 8'd1;
  assign exp_dec = exp_i - 8'd1;

  always_comb begin
    mag_o    = mag_i;
    exp_o    = exp_i;
    cnt_o    = cnt_i;
    done_o   = 1'b0;
    result_o = '0;
    ovf_o    = 1'b0;
    unf_o    = 1'b0;
    zero_o   = 1'b0;
    if (mag_i == '0) begin
      done_o = 1'b1;
      zero_o = 1'b1;
    end else if (mag_i[MANT_W]) begin
      // Carry out: truncating right shift.
      mag_o = mag_i >> 1;
      exp_o = exp_inc;
      if (exp_inc == EXP_MAX) begin
        done_o   = 1'b1;
        ovf_o    = 1'b1;
        result_o = pack_fp(sign_i, EXP_MAX, 23'h0);
      end
    end else if (!mag_i[MANT_W-1]) begin
      if (exp_i <= 8'd1 || cnt_i >= CntMax) begin
        done_o   = 1'b1;
        unf_o    = 1'b1;
        result_o = {sign_i, 31'h0};
      end else begin
        mag_o = mag_i << 1;
        exp_o = exp_dec;
        cnt_o = cnt_i + 1'b1;
      end
    end else begin
      done_o   = 1'b1;
      result_o = pack_fp(sign_i, exp_i, mag_i[22:0]);
    end
  end

endmodule

// File: rtl/fp_mant_add_norm.sv
// Mantissa add/subtract with iterative normalization and IEEE-754 single packing.
// One operation in flight; valid/ready on both sides.
module fp_mant_add_norm
  import fp_pkg::*;
#(
  parameter int unsigned MAX_LSHIFT = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] norm_l,
  input  logic [31:0] norm_s,
  input  logic        sign_l,
  input  logic        sign_s,
  input  logic [7:0]  exp_l,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ovf,
  output logic        unf,
  output logic        zero
);

  localparam int unsigned CntW = $clog2(MAX_LSHIFT + 1);

  state_e              state_q, state_d;
  logic [MANT_W-1:0]   l_q, l_d, s_q, s_d;
  logic                sl_q, sl_d, ss_q, ss_d;
  logic [MANT_W:0]     mag_q, mag_d;
  logic [7:0]          exp_q, exp_d;
  logic                sign_q, sign_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [31:0]         result_q, result_d;
  logic                ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;

  logic [MANT_W:0]     ns_mag;
  logic [7:0]          ns_exp;
  logic [CntW-1:0]     ns_cnt;
  logic                ns_done, ns_ovf, ns_unf, ns_zero;
  logic [31:0]         ns_result;

  logic                unused_hi;
  assign unused_hi = ^{norm_l[31:MANT_W], norm_s[31:MANT_W]};

  fp_norm_shift #(
    .MAX_LSHIFT(MAX_LSHIFT),
    .CNT_W     (CntW)
  ) u_norm_shift (
    .mag_i   (mag_q),
    .exp_i   (exp_q),
    .sign_i  (sign_q),
    .cnt_i   (cnt_q),
    .mag_o   (ns_mag),
    .exp_o   (ns_exp),
    .cnt_o   (ns_cnt),
    .done_o  (ns_done),
    .result_o(ns_result),
    .ovf_o   (ns_ovf),
    .unf_o   (ns_unf),
    .zero_o  (ns_zero)
  );

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    s_d      = s_q;
    sl_d     = sl_q;
    ss_d     = ss_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    zero_d   = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          l_d     = norm_l[MANT_W-1:0];
          s_d     = norm_s[MANT_W-1:0];
          sl_d    = sign_l;
          ss_d    = sign_s;
          exp_d   = exp_l;
          state_d = StAdd;
        end
      end
      StAdd: begin
        cnt_d = '0;
        if (exp_q == EXP_MAX) begin
          // Inf/NaN operands are unsupported; report a quiet NaN.
          result_d = QNAN;
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
          zero_d   = 1'b0;
          state_d  = StOut;
        end else begin
          if (sl_q == ss_q) begin
            mag_d  = {1'b0, l_q} + {1'b0, s_q};
            sign_d = sl_q;
          end else if (l_q >= s_q) begin
            mag_d  = {1'b0, l_q} - {1'b0, s_q};
            sign_d = sl_q;
          end else begin
            mag_d  = {1'b0, s_q} - {1'b0, l_q};
            sign_d = ss_q;
          end
          state_d = StNorm;
        end
      end
      StNorm: begin
        mag_d = ns_mag;
        exp_d = ns_exp;
        cnt_d = ns_cnt;
        if (ns_done) begin
          result_d = ns_result;
          ovf_d    = ns_ovf;
          unf_d    = ns_unf;
          zero_d   = ns_zero;
          state_d  = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      l_q      <= '0;
      s_q      <= '0;
      sl_q     <= 1'b0;
      ss_q     <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      l_q      <= l_d;
      s_q      <= s_d;
      sl_q     <= sl_d;
      ss_q     <= ss_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_fp_mant_add_norm.sv
// Randomized bench for fp_mant_add_norm against a leading-one based reference model.
module tb_fp_mant_add_norm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] norm_l = '0;
  logic [31:0] norm_s = '0;
  logic        sign_l = 1'b0;
  logic        sign_s = 1'b0;
  logic [7:0]  exp_l = '0;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        ovf, unf, zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_mant_add_norm #(.MAX_LSHIFT(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .norm_l   (norm_l),
    .norm_s   (norm_s),
    .sign_l   (sign_l),
    .sign_s   (sign_s),
    .exp_l    (exp_l),
    .result   (result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf      (ovf),
    .unf      (unf),
    .zero     (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum, then place the leading one at bit 23.
  function automatic void model(input logic [23:0] l, input logic [23:0] s,
                                input logic sl, input logic ss, input logic [7:0] e,
                                output logic [31:0] res, output logic ov,
                                output logic un, output logic zr, output int lat);
    int mag, p, n, ei, m;
    logic sg;
    res = '0; ov = 0; un = 0; zr = 0; lat = 3;
    ei = int'(e);
    if (ei == 255) begin
      res = 32'h7FC00000; ov = 1; lat = 2;
      return;
    end
    if (sl == ss) begin mag = int'(l) + int'(s); sg = sl; end
    else if (l >= s) begin mag = int'(l) - int'(s); sg = sl; end
    else begin mag = int'(s) - int'(l); sg = ss; end
    if (mag == 0) begin
      zr = 1;
      return;
    end
    p = $clog2(mag + 1) - 1;
    if (p == 24) begin
      if (ei + 1 == 255) begin
        res = {sg, 8'hFF, 23'h0}; ov = 1; lat = 3;
      end else begin
        m = mag >> 1;
        res = {sg, 8'(ei + 1), m[22:0]}; lat = 4;
      end
    end else begin
      n = 23 - p;
      if (n > 0 && ei <= n) begin
        res = {sg, 31'h0}; un = 1;
        lat = 3 + ((ei >= 1) ? ei - 1 : 0);
      end else begin
        m = mag << n;
        res = {sg, 8'(ei - n), m[22:0]}; lat = 3 + n;
      end
    end
  endfunction

  task automatic run_op(input logic [23:0] l, input logic [23:0] s, input logic sl,
                        input logic ss, input logic [7:0] e, input int hold, input string tag);
    logic [31:0] er;
    logic eo, eu, ez;
    int el, lat, w;
    model(l, s, sl, ss, e, er, eo, eu, ez, el);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    norm_l = {8'h0, l}; norm_s = {8'h0, s};
    sign_l = sl; sign_s = ss; exp_l = e; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    check({tag, ".lat"}, 32'(lat), 32'(el));
    check({tag, ".result"}, result, er);
    check({tag, ".flags"}, {29'h0, ovf, unf, zero}, {29'h0, eo, eu, ez});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; norm_l = $urandom; norm_s = $urandom; exp_l = 8'($urandom);
      @(posedge clk); #1;
      check({tag, ".hold"}, {result, 1'b0, out_valid, in_ready, ovf, unf, zero},
            {er, 1'b0, 1'b1, 1'b0, eo, eu, ez});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ".release"}, {28'h0, out_valid, ovf, unf, zero}, 32'h0);
    check({tag, ".idle"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [23:0] l, s;
    logic [7:0] e;
    int sel, lat;
    #12;
    check("reset.outputs", {result[30:0], out_valid}, 32'h0);
    check("reset.flags", {29'h0, ovf, unf, zero}, 32'h0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(24'h800000, 24'h800000, 0, 0, 8'd127, 0, "one_plus_one");
    run_op(24'hC00000, 24'hC00000, 0, 1, 8'd127, 0, "cancel");
    run_op(24'h800000, 24'h600000, 0, 1, 8'd127, 0, "one_minus_0.75");
    run_op(24'h800000, 24'hC00000, 0, 1, 8'd127, 0, "s_gt_l");
    run_op(24'hFFFFFF, 24'hFFFFFF, 0, 0, 8'd254, 0, "overflow");
    run_op(24'h800000, 24'h7FFFFF, 0, 1, 8'd1, 0, "underflow");
    run_op(24'h800000, 24'h000001, 1, 1, 8'd255, 0, "nan_in");
    run_op(24'h900000, 24'h100000, 1, 0, 8'd3, 5, "backpressure");

    // Reset in the middle of a left-normalize sequence.
    @(negedge clk);
    norm_l = 32'h00800000; norm_s = 32'h00600000;
    sign_l = 0; sign_s = 1; exp_l = 8'd127; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst.outputs", result, 32'h0);
    check("midrst.ctrl", {27'h0, out_valid, in_ready, ovf, unf, zero}, 32'h8);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    check("midrst.no_result", 32'(lat), 32'd0);
    run_op(24'h800000, 24'h600000, 0, 1, 8'd127, 0, "after_reset");

    for (int t = 0; t < 250; t++) begin
      l = 24'h800000 | 24'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0) s = l - 24'($urandom_range(0, 4096));
      else if (sel == 1) s = 24'h800000 | 24'($urandom);
      else s = l >> $urandom_range(0, 24);
      sel = $urandom_range(0, 15);
      if (sel == 0) e = 8'd255;
      else if (sel < 4) e = 8'($urandom_range(1, 20));
      else if (sel < 6) e = 8'($urandom_range(250, 254));
      else e = 8'($urandom_range(21, 249));
      run_op(l, s, 1'($urandom), 1'($urandom), e, $urandom_range(0, 2), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_mant_add_norm.md
Name: fp_mant_add_norm

Overview:
- Downstream neighbour of the exponent-compare/alignment stage in the 32-bit FP adder datapath.
- Takes the aligned larger and smaller mantissas, both signs and the larger exponent. Adds or subtracts the mantissas, normalizes the result with a multi-cycle shifter, and packs an IEEE-754 single.
- Valid/ready handshake on both sides. One operation in flight at a time.

Parameters:
- MAX_LSHIFT, 24, hard bound on left-normalize iterations (safety limit for the counter).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operands valid.
- in_ready  output  1  block can accept; high only in IDLE.
- norm_l  input  32  aligned larger mantissa; bits [23:0] used, bit 23 is the hidden 1.
- norm_s  input  32  aligned smaller mantissa, already right-shifted; bits [23:0] used.
- sign_l  input  1  sign of the larger operand.
- sign_s  input  1  sign of the smaller operand.
- exp_l  input  8  biased exponent of the larger operand.
- result  output  32  packed single-precision sum.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- ovf  output  1  overflow to infinity.
- unf  output  1  underflow flushed to zero.
- zero  output  1  exact zero result.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - result, out_valid, ovf, unf and zero all go to 0; in_ready goes to 1 once the block is in IDLE.
  - Reset asserted mid-operation abandons the operation; no partial result is ever presented.
- FSM states: IDLE, ADD, NORM, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: register norm_l[23:0], norm_s[23:0], both signs and exp_l, then go to ADD.
- ADD (1 cycle):
  - sign_l==sign_s: mag = L + S, 25-bit; sign = sign_l.
  - Signs differ, L>=S: mag = L - S; sign = sign_l.
  - Signs differ, S>L (only possible when exponents were equal): mag = S - L; sign = sign_s.
  - Next state is NORM.
- NORM, evaluated once per cycle with priority in this order:
  - mag==0: sign=0, exp=0, zero=1, go to OUT.
  - mag[24]=1: mag >>= 1 with the shifted-out bit truncated; exp += 1.
    - If the new exp==255: result=+/-inf ({sign,8'hFF,23'h0}), ovf=1, go to OUT.
    - Otherwise stay in NORM.
  - mag[23]=0:
    - If exp<=1: flush to {sign,31'h0}, unf=1, go to OUT.
    - Otherwise mag <<= 1, exp -= 1, increment the shift count and stay in NORM.
    - If the count reaches MAX_LSHIFT: flush as for underflow.
  - Otherwise (already normalized): result = {sign, exp, mag[22:0]}, go to OUT.
- Rounding is truncation (round toward zero), consistent with the truncating alignment stage upstream.
- exp_l==255 input (inf/NaN) is not supported. It yields result 32'h7FC00000 with ovf=1, going directly from ADD to OUT.
- OUT:
  - out_valid=1; result and flags held stable.
  - On out_ready=1: go to IDLE; out_valid and flags clear on the same edge.
  - If out_ready stays low, the result and flags are held indefinitely and in_ready stays 0.
- Latency, counted in clock edges from the accepting edge to out_valid high:
  - 3 when the sum is already normalized or zero.
  - +1 for a carry-out right shift.
  - +k for k left shifts.
- Throughput: 1 operation per (latency + 1) cycles minimum. No back-to-back acceptance.
- Flags are mutually exclusive. All internal registers are reset asynchronously.

Decomposition:
- Package fp_pkg:
  - state enum (IDLE, ADD, NORM, OUT).
  - EXP_MAX=8'hFF.
  - QNAN=32'h7FC00000.
  - MANT_W=24.
  - Packing helper function {sign,exp,frac}.
- One natural sub-module: fp_norm_shift.
  - Holds the NORM-step combinational decision: shift direction, next exp, terminal condition.
  - Keeps the FSM file thin.
- Everything else stays in fp_mant_add_norm.

Test Plan:
1. 1.0+1.0: norm_l=norm_s=32'h00800000, signs 0, exp_l=127 -> result 32'h40000000, flags 0, out_valid 4 edges after accept.
2. 1.5+(-1.5): L=S=32'h00C00000, sign_s=1, exp_l=127 -> result 32'h00000000, zero=1, latency 3.
3. 1.0-0.75: L=32'h00800000, S=32'h00600000, sign_s=1, exp_l=127 -> 32'h3E800000 (0.25), 2 left shifts, latency 5.
4. Equal exponents with S>L: L=32'h00800000 (+), S=32'h00C00000 (sign 1), exp_l=127 -> 32'hBF000000 (-0.5).
5. Overflow and underflow:
   - exp_l=254, L=S=32'h00FFFFFF, same sign -> 32'h7F800000, ovf=1.
   - exp_l=1, L=32'h00800000, S=32'h007FFFFF, sign_s=1 -> 32'h00000000, unf=1.
6. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles -> result stable, in_ready=0, new in_valid ignored.
   - Assert rst_n=0 during NORM of case 3 -> outputs immediately 0, IDLE; the next operation completes correctly.
